mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
//  E-stage multiply/divide unit of the 5-stage MIPS pipeline. Executes mult/multu/div/divu with
//  fixed multi-cycle latency and owns the HI/LO registers. Serves mthi/mtlo/mfhi/mflo.
//  Drives the Start/Busy pair that the hazard unit uses to stall MDU instructions in D.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a mult/multu start (>=1)
//  DIV_CYCLES   10  busy cycles after a div/divu start (>=1)
// PORTS
//  clk      in   1   single clock, rising edge
//  reset    in   1   asynchronous, active-high; clears HI, LO, counter, pending result
//  Req      in   1   exception/interrupt taken this cycle; squashes the E-stage MDU op
//  MDUop    in   4   E-stage op: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO (+MADD set)
//  A        in   32  forwarded rs value
//  B        in   32  forwarded rt value
//  Start    out  1   comb: MDUop in {MULT,MULTU,DIV,DIVU(,MADD*)} && !Req && !Busy
//  Busy     out  1   registered: operation in flight
//  HI       out  32  architectural HI
//  LO       out  32  architectural LO
//  MDU_out  out  32  comb: HI if MFHI, LO if MFLO, else 0
// BEHAVIOUR
//  Reset (async): HI=LO=0, Busy=0, cnt=0, pending regs=0. Start, MDU_out follow comb rules.
//  States: IDLE (cnt==0) -> RUN (cnt>0) -> IDLE.
//  IDLE, Start=1 at edge t: result computed at once into pend_hi/pend_lo; cnt<=MULT_CYCLES or
//   DIV_CYCLES; Busy=1 from cycle t+1 through t+N inclusive.
//  RUN: cnt decrements each edge; at the edge where cnt==1: HI<=pend_hi, LO<=pend_lo, Busy<=0.
//   New HI/LO first visible in cycle t+N+1; Start may re-assert that same cycle.
//  Arithmetic: MULT signed 32x32->64 {HI,LO}; MULTU unsigned. DIV: LO=quotient, HI=remainder,
//   signed, truncate toward zero (remainder takes dividend's sign); DIVU unsigned.
//  Divide by zero: busy sequence runs normally; HI/LO left unchanged at commit.
//  MTHI/MTLO: HI<=A / LO<=A at next edge, only when !Busy && !Req; ignored when Busy.
//   (Hazard unit guarantees no MDU op reaches E while Busy|Start; the Busy gating is a safety net.)
//  Req=1: E-stage op has no effect (no Start, no MT write); an op already in RUN is NOT
//   cancelled and commits at its scheduled edge.
//  Reset mid-RUN: pending result discarded, HI/LO=0, Busy=0 immediately.
//  MFHI/MFLO during RUN return the old HI/LO (stall upstream prevents this in normal flow).
// CONFIGURATION
//  MDU_MADD_EN defined: adds MADD, MADDU, MSUB, MSUBU ops. Latency MULT_CYCLES;
//   pend = {HI,LO} +/- product (64-bit, wraparound, signed/unsigned per op) sampled at Start.
//   Hazard unit must then also stall these ops on Busy|Start.
//  Not defined: those MDUop codes decode as NONE (no Start, no state change).
// STRUCTURE
//  MDUop encodings and MULT/DIV latency defaults go in the shared constant.v macro file,
//   consumed by controller and hazard unit.
//  No sub-module; datapath (64-bit product, quotient/remainder) plus one counter FSM live in this file.
// TESTING
//  1 mult A=0xFFFFFFFF B=2, no Req -> Busy cycles t+1..t+5; HI=0xFFFFFFFF LO=0xFFFFFFFE at t+6.
//  2 divu A=7 B=2 -> Busy 10 cycles; LO=3 HI=1. div A=-7 B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
//  3 mthi A=0x1234 then mfhi -> MDU_out=0x1234; div by 0 after it -> HI still 0x1234 after commit.
//  4 mult with Req=1 same cycle -> Start=0, Busy stays 0, HI/LO unchanged.
//  5 reset at cycle 3 of a div -> Busy=0, HI=LO=0 asynchronously; no later commit occurs.
//  6 MDU_MADD_EN: HI=0 LO=0xFFFFFFFF, maddu A=1 B=1 -> HI=1 LO=0 after 5 busy cycles.

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// Shared constants for the MIPS multiply/divide unit: MDUop encodings, default latencies and the HI/LO pair type.
// The MADD family codes are only decoded when MDU_MADD_EN is defined.
package mdu_unit_pkg;

    typedef logic [3:0] mdu_op_t;

    localparam mdu_op_t OP_NONE  = 4'd0;
    localparam mdu_op_t OP_MULT  = 4'd1;
    localparam mdu_op_t OP_MULTU = 4'd2;
    localparam mdu_op_t OP_DIV   = 4'd3;
    localparam mdu_op_t OP_DIVU  = 4'd4;
    localparam mdu_op_t OP_MFHI  = 4'd5;
    localparam mdu_op_t OP_MFLO  = 4'd6;
    localparam mdu_op_t OP_MTHI  = 4'd7;
    localparam mdu_op_t OP_MTLO  = 4'd8;
    localparam mdu_op_t OP_MADD  = 4'd9;
    localparam mdu_op_t OP_MADDU = 4'd10;
    localparam mdu_op_t OP_MSUB  = 4'd11;
    localparam mdu_op_t OP_MSUBU = 4'd12;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

endpackage

// File: rtl/mdu_unit_if.sv
// E-stage bus between the pipeline and the MDU: operands, op, squash request, Start/Busy handshake and HI/LO results.
interface mdu_unit_if;
    import mdu_unit_pkg::*;

    logic        Req;
    mdu_op_t     MDUop;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_out;

    modport master (output Req, MDUop, A, B, input Start, Busy, HI, LO, MDU_out);
    modport slave  (input Req, MDUop, A, B, output Start, Busy, HI, LO, MDU_out);

endinterface

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: fixed-latency mult/div into a pending HI/LO pair, committed after the busy window.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU (accumulate into {HI,LO}, multiply latency).
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic       clk,
    input logic       reset,
    mdu_unit_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    hilo_t            pend_q, pend_d;
    logic             pend_we_q, pend_we_d;

    logic isMul, isDiv, isSigned, start;
`ifdef MDU_MADD_EN
    logic isAcc, isSub;
`endif

    always_comb begin
        isMul    = 1'b0;
        isDiv    = 1'b0;
        isSigned = 1'b0;
`ifdef MDU_MADD_EN
        isAcc    = 1'b0;
        isSub    = 1'b0;
`endif
        case (bus.MDUop)
            OP_MULT:  begin isMul = 1'b1; isSigned = 1'b1; end
            OP_MULTU: isMul = 1'b1;
            OP_DIV:   begin isDiv = 1'b1; isSigned = 1'b1; end
            OP_DIVU:  isDiv = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin isMul = 1'b1; isSigned = 1'b1; isAcc = 1'b1; end
            OP_MADDU: begin isMul = 1'b1; isAcc = 1'b1; end
            OP_MSUB:  begin isMul = 1'b1; isSigned = 1'b1; isAcc = 1'b1; isSub = 1'b1; end
            OP_MSUBU: begin isMul = 1'b1; isAcc = 1'b1; isSub = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Low 64 bits of a 64x64 product of extended operands are correct for both signed and unsigned.
    logic [63:0] opA64, opB64, product, mulResult;
    assign opA64   = isSigned ? {{32{bus.A[31]}}, bus.A} : {32'b0, bus.A};
    assign opB64   = isSigned ? {{32{bus.B[31]}}, bus.B} : {32'b0, bus.B};
    assign product = opA64 * opB64;
`ifdef MDU_MADD_EN
    assign mulResult = !isAcc ? product :
                       isSub  ? ({hi_q, lo_q} - product) : ({hi_q, lo_q} + product);
`else
    assign mulResult = product;
`endif

    // Signed divide via magnitudes so INT_MIN / -1 wraps deterministically.
    logic        divZero, negA, negB;
    logic [31:0] divisor, magA, magB, uQuot, uRem, quot, rem;
    assign divZero = (bus.B == 32'd0);
    assign divisor = divZero ? 32'd1 : bus.B;
    assign negA    = isSigned & bus.A[31];
    assign negB    = isSigned & divisor[31];
    assign magA    = negA ? -bus.A : bus.A;
    assign magB    = negB ? -divisor : divisor;
    assign uQuot   = magA / magB;
    assign uRem    = magA % magB;
    assign quot    = (negA ^ negB) ? -uQuot : uQuot;
    assign rem     = negA ? -uRem : uRem;

    assign start = (isMul | isDiv) & ~bus.Req & (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_we_d = pend_we_q;
        if (state_q == ST_RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                if (pend_we_q) begin
                    hi_d = pend_q.hi;
                    lo_d = pend_q.lo;
                end
            end
        end else if (start) begin
            state_d   = ST_RUN;
            cnt_d     = isDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_we_d = ~(isDiv & divZero);
            pend_d    = isDiv ? {rem, quot} : mulResult;
        end else if (!bus.Req) begin
            if (bus.MDUop == OP_MTHI) hi_d = bus.A;
            if (bus.MDUop == OP_MTLO) lo_d = bus.A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign bus.Start   = start;
    assign bus.Busy    = (state_q == ST_RUN);
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
    assign bus.MDU_out = (bus.MDUop == OP_MFHI) ? hi_q :
                         (bus.MDUop == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed scenarios plus randomized ops against a cycle-count reference model of HI/LO.
// Honours MDU_MADD_EN the same way as the design.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checkCount = 0;
    int   passCount = 0;

    mdu_unit_if mdu ();

    mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mdu)
    );

    always #5 clk = ~clk;

    // Reference model: architectural HI/LO plus one pending result due at an absolute edge number.
    logic [31:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;
    bit          pending = 1'b0, pWe = 1'b0;
    int          edgeNum = 0, commitEdge = 0;

    function automatic bit isMdOp(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= OP_MULT && op <= OP_DIVU) || (op >= OP_MADD && op <= OP_MSUBU);
`else
        return (op >= OP_MULT && op <= OP_DIVU);
`endif
    endfunction

    function automatic void modelResult(input logic [3:0] op, input logic [31:0] a, b,
                                        input logic [63:0] acc,
                                        output logic [63:0] res, output bit we);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        up = {32'b0, a} * {32'b0, b};
        we = 1'b1;
        res = '0;
        case (op)
            OP_MULT:  res = sp;
            OP_MULTU: res = up;
            OP_DIV:   if (b == 0) we = 1'b0; else res = {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  if (b == 0) we = 1'b0; else res = {a % b, a / b};
            OP_MADD:  res = acc + sp;
            OP_MADDU: res = acc + up;
            OP_MSUB:  res = acc - sp;
            OP_MSUBU: res = acc - up;
            default:  we = 1'b0;
        endcase
    endfunction

    function automatic void modelEdge(input logic [3:0] op, input logic [31:0] a, b, input logic req);
        bit          wasBusy;
        logic [63:0] res;
        bit          we;
        edgeNum++;
        wasBusy = pending;
        if (pending && edgeNum == commitEdge) begin
            if (pWe) begin
                mHi = pHi;
                mLo = pLo;
            end
            pending = 1'b0;
        end
        if (!wasBusy && !req) begin
            if (isMdOp(op)) begin
                modelResult(op, a, b, {mHi, mLo}, res, we);
                {pHi, pLo} = res;
                pWe = we;
                pending = 1'b1;
                commitEdge = edgeNum + ((op == OP_DIV || op == OP_DIVU) ? DIV_N : MULT_N);
            end else if (op == OP_MTHI) begin
                mHi = a;
            end else if (op == OP_MTLO) begin
                mLo = a;
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed %h expected %h (t=%0t)", tag, observed, expected, $time);
        else
            passCount++;
    endtask

    // Drives one E-stage cycle, checks current outputs against the model, then clocks the model.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, b, input logic req);
        logic [31:0] expOut;
        mdu.MDUop = op;
        mdu.A     = a;
        mdu.B     = b;
        mdu.Req   = req;
        #1;
        expOut = (op == OP_MFHI) ? mHi : (op == OP_MFLO) ? mLo : 32'd0;
        checkOutput("busy",    32'(mdu.Busy),  32'(pending));
        checkOutput("start",   32'(mdu.Start), 32'(isMdOp(op) && !req && !pending));
        checkOutput("hi",      mdu.HI, mHi);
        checkOutput("lo",      mdu.LO, mLo);
        checkOutput("mdu_out", mdu.MDU_out, expOut);
        @(posedge clk);
        modelEdge(op, a, b, req);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [3:0]  rOp;
        logic [31:0] rA, rB;
        logic        rReq;

        mdu.MDUop = OP_NONE;
        mdu.A = '0;
        mdu.B = '0;
        mdu.Req = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(mdu.Busy), 32'd0);
        checkOutput("rst_hi", mdu.HI, 32'd0);
        checkOutput("rst_lo", mdu.LO, 32'd0);
        reset = 1'b0;
        idle(2);

        applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(MULT_N);
        checkOutput("mult_hi", mdu.HI, 32'hFFFF_FFFF);
        checkOutput("mult_lo", mdu.LO, 32'hFFFF_FFFE);

        applyStimulus(OP_DIVU, 32'd7, 32'd2, 1'b0);
        idle(DIV_N);
        checkOutput("divu_lo", mdu.LO, 32'd3);
        checkOutput("divu_hi", mdu.HI, 32'd1);

        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DIV_N);
        checkOutput("div_lo", mdu.LO, 32'hFFFF_FFFD);
        checkOutput("div_hi", mdu.HI, 32'hFFFF_FFFF);

        applyStimulus(OP_MTHI, 32'h0000_1234, 32'd0, 1'b0);
        mdu.MDUop = OP_MFHI;
        #1;
        checkOutput("mfhi", mdu.MDU_out, 32'h0000_1234);
        applyStimulus(OP_MFHI, 32'd0, 32'd0, 1'b0);
        applyStimulus(OP_DIV, 32'd5, 32'd0, 1'b0);
        idle(DIV_N + 1);
        checkOutput("div0_hi", mdu.HI, 32'h0000_1234);
        checkOutput("div0_lo", mdu.LO, 32'hFFFF_FFFD);

        applyStimulus(OP_MULT, 32'd3, 32'd4, 1'b1);
        checkOutput("req_busy", 32'(mdu.Busy), 32'd0);
        idle(MULT_N + 1);
        checkOutput("req_hi", mdu.HI, 32'h0000_1234);

        applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0);
        idle(2);
        #1 reset = 1'b1;
        #1;
        checkOutput("amid_busy", 32'(mdu.Busy), 32'd0);
        checkOutput("amid_hi", mdu.HI, 32'd0);
        checkOutput("amid_lo", mdu.LO, 32'd0);
        reset = 1'b0;
        mHi = '0;
        mLo = '0;
        pending = 1'b0;
        idle(DIV_N + 2);
        checkOutput("nocommit_lo", mdu.LO, 32'd0);

`ifdef MDU_MADD_EN
        applyStimulus(OP_MTHI, 32'd0, 32'd0, 1'b0);
        applyStimulus(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
        applyStimulus(OP_MADDU, 32'd1, 32'd1, 1'b0);
        idle(MULT_N);
        checkOutput("maddu_hi", mdu.HI, 32'd1);
        checkOutput("maddu_lo", mdu.LO, 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            rOp  = 4'($urandom_range(0, 12));
            rA   = $urandom;
            rB   = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            rReq = ($urandom_range(0, 7) == 0);
            if (rOp == OP_DIV && rA == 32'h8000_0000 && rB == 32'hFFFF_FFFF) rB = 32'd1;
            applyStimulus(rOp, rA, rB, rReq);
        end
        idle(DIV_N + 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
